// File: rtl/stage_memory.sv
// stage_memory: RV32IM memory stage -- loads/stores over a req/ack bus, branch redirect, writeback register.
// Optional MEM_ALIGN_CHECK_EN adds mem_misaligned and suppresses misaligned bus requests.
module stage_memory (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic [31:0] mem_data0,
   input  logic [31:0] mem_data1,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_extend,
   input  logic [1:0]  mem_width,
   input  logic        mem_jmp,
   input  logic        mem_br,
   input  logic        mem_br_inv,
   input  logic [4:0]  wb_reg,
   output logic        mem_stall,
   output logic        br_taken,
   output logic [31:0] br_target,
   output logic [31:0] mem_forward_data,
   output logic        mem_wen,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_reg_r
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        mem_misaligned
`endif
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state;
   logic [1:0]  a;
   logic        access, mis, wb_load;
   logic [7:0]  lb;
   logic [15:0] lh;
   logic [31:0] ld;
   logic        unused_pc;
   assign unused_pc = ^mem_pc;
   assign a = mem_data0[1:0];
   assign access = mem_valid & (mem_read | mem_write);
`ifdef MEM_ALIGN_CHECK_EN
   assign mis = access & (((mem_width == 2'd1) & a[0]) | (mem_width[1] & (a != 2'd0)));
   assign mem_misaligned = mis;
`else
   assign mis = 1'b0;
`endif
   // Inputs are frozen by the stall, so the request stays stable through WAIT.
   assign dmem_req = ~reset & access & ~mis;
   assign mem_stall = access & ~mis & ~dmem_ack;
   assign dmem_we = dmem_req & mem_write;
   assign dmem_addr = {mem_data0[31:2], 2'b00};
   assign dmem_wdata = mem_width == 2'd0 ? {4{mem_data1[7:0]}} :
                       mem_width == 2'd1 ? {2{mem_data1[15:0]}} : mem_data1;
   assign dmem_wstrb = mem_width == 2'd0 ? 4'b0001 << a :
                       mem_width == 2'd1 ? 4'b0011 << {a[1], 1'b0} : 4'hF;
   assign lb = dmem_rdata[{a, 3'b000} +: 8];
   assign lh = dmem_rdata[{a[1], 4'b0000} +: 16];
   assign ld = mem_width == 2'd0 ? {{24{mem_extend & lb[7]}}, lb} :
               mem_width == 2'd1 ? {{16{mem_extend & lh[15]}}, lh} : dmem_rdata;
   assign br_taken = mem_valid & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
   assign br_target = {mem_data1[31:1], 1'b0};
   assign mem_forward_data = mem_read ? ld : mem_data0;
   assign mem_wen = mem_valid & ~mem_write & ~mis & (wb_reg != 5'd0) & (~mem_read | dmem_ack);
   assign wb_load = mem_valid & ~mem_stall;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wb_valid <= 1'b0;
         wb_data <= 32'd0;
         wb_reg_r <= 5'd0;
      end else begin
         state <= state == IDLE ? ((dmem_req & ~dmem_ack) ? WAIT : IDLE) : (dmem_ack ? IDLE : WAIT);
         wb_valid <= wb_load;
         if (wb_load) begin
            wb_data <= mem_forward_data;
            wb_reg_r <= (mem_write | mem_br | mis) ? 5'd0 : wb_reg;
         end
      end
   end
endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: vector table, hand-written stall/reset sequences and randomized checks against a reference model.
module tb_stage_memory;
   logic clk = 0, reset = 1;
   logic mem_valid = 0, mem_read = 0, mem_write = 0, mem_extend = 0, mem_jmp = 0, mem_br = 0, mem_br_inv = 0;
   logic [31:0] mem_pc = 0, mem_data0 = 0, mem_data1 = 0, dmem_rdata = 0;
   logic [1:0] mem_width = 0;
   logic [4:0] wb_reg = 0;
   logic dmem_ack = 0;
   logic mem_stall, br_taken, mem_wen, dmem_req, dmem_we, wb_valid;
   logic [31:0] br_target, mem_forward_data, dmem_addr, dmem_wdata, wb_data;
   logic [3:0] dmem_wstrb;
   logic [4:0] wb_reg_r;
   int checks = 0, errors = 0;

   stage_memory dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_data0(mem_data0),
      .mem_data1(mem_data1), .mem_read(mem_read), .mem_write(mem_write), .mem_extend(mem_extend),
      .mem_width(mem_width), .mem_jmp(mem_jmp), .mem_br(mem_br), .mem_br_inv(mem_br_inv),
      .wb_reg(wb_reg), .mem_stall(mem_stall), .br_taken(br_taken), .br_target(br_target),
      .mem_forward_data(mem_forward_data), .mem_wen(mem_wen), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg_r(wb_reg_r)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, got, exp);
      end
   endtask

   typedef struct {
      logic mv; logic [31:0] d0, d1; logic rd, wr, ext; logic [1:0] w;
      logic jmp, br, inv; logic [4:0] rg; logic ack; logic [31:0] rdata;
      logic e_stall, e_tk; logic [31:0] e_tgt, e_fwd; logic e_wen;
      logic [31:0] e_wdata; logic [3:0] e_wstrb;
      logic e_wbv; logic [31:0] e_wbd; logic [4:0] e_wbr;
   } vec_t;

   task automatic set_in(logic mv, logic [31:0] d0, logic [31:0] d1, logic rd, logic wr, logic ext,
                         logic [1:0] w, logic jmp, logic br, logic inv, logic [4:0] rg);
      mem_valid = mv; mem_data0 = d0; mem_data1 = d1; mem_read = rd; mem_write = wr;
      mem_extend = ext; mem_width = w; mem_jmp = jmp; mem_br = br; mem_br_inv = inv; wb_reg = rg;
      mem_pc = mem_pc + 4;
   endtask

   // Reference model: outputs derived directly from the bus/lane rules with integer arithmetic.
   logic m_stall, m_req, m_we, m_tk, m_wen, m_wbv;
   logic [31:0] m_addr, m_wdata, m_tgt, m_fwd, m_wbd;
   logic [3:0] m_wstrb;
   logic [4:0] m_wbr;

   task automatic model();
      int a;
      logic acc;
      logic [31:0] v;
      a = int'(mem_data0 % 4);
      acc = mem_valid && (mem_read || mem_write);
      m_req = acc;
      m_stall = acc && !dmem_ack;
      m_we = acc && mem_write;
      m_addr = mem_data0 - 32'(a);
      if (mem_width == 0) begin
         m_wdata = (mem_data1 & 32'hFF) * 32'h01010101;
         m_wstrb = 4'(1 << a);
         v = (dmem_rdata >> (8 * a)) & 32'hFF;
         if (mem_extend && v >= 128) v = v - 256;
      end else if (mem_width == 1) begin
         m_wdata = (mem_data1 & 32'hFFFF) * 32'h00010001;
         m_wstrb = a >= 2 ? 4'd12 : 4'd3;
         v = (dmem_rdata >> (16 * (a / 2))) & 32'hFFFF;
         if (mem_extend && v >= 32768) v = v - 65536;
      end else begin
         m_wdata = mem_data1;
         m_wstrb = 4'd15;
         v = dmem_rdata;
      end
      m_tk = mem_valid && (mem_jmp || (mem_br && ((mem_data0 % 2 == 1) != mem_br_inv)));
      m_tgt = mem_data1 - (mem_data1 % 2);
      m_fwd = mem_read ? v : mem_data0;
      m_wen = mem_valid && !mem_write && wb_reg != 0 && (!mem_read || dmem_ack);
   endtask

   task automatic model_clock();
      if (mem_valid && !m_stall) begin
         m_wbv = 1; m_wbd = m_fwd; m_wbr = (mem_write || mem_br) ? 5'd0 : wb_reg;
      end else m_wbv = 0;
   endtask

   vec_t vt[7];
   int req_cycles, stall_cycles;

   initial begin
      vt[0] = '{1, 32'h1003, 0, 1, 0, 1, 0, 0, 0, 0, 5, 1, 32'h80FF1234,
                0, 0, 0, 32'hFFFFFF80, 1, 0, 0, 1, 32'hFFFFFF80, 5};
      vt[1] = '{1, 32'h12, 32'h1234ABCD, 0, 1, 0, 1, 0, 0, 0, 7, 1, 0,
                0, 0, 32'h1234ABCC, 32'h12, 0, 32'hABCDABCD, 4'b1100, 1, 32'h12, 0};
      vt[2] = '{1, 0, 32'h201, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,
                0, 1, 32'h200, 0, 0, 32'h01010101, 4'b0001, 1, 0, 0};
      vt[3] = '{1, 0, 32'h201, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,
                0, 0, 32'h200, 0, 0, 32'h01010101, 4'b0001, 1, 0, 0};
      vt[4] = '{1, 32'h104, 32'h400, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0,
                0, 1, 32'h400, 32'h104, 1, 32'h400, 4'hF, 1, 32'h104, 1};
      vt[5] = '{1, 32'h21, 0, 1, 0, 1, 1, 0, 0, 0, 9, 1, 32'hAABBCCDD,
                0, 0, 0, 32'hFFFFCCDD, 1, 0, 4'b0011, 1, 32'hFFFFCCDD, 9};
      vt[6] = '{0, 32'h40, 0, 1, 0, 0, 2, 1, 0, 0, 3, 0, 32'h55,
                0, 0, 0, 32'h55, 0, 0, 4'hF, 0, 32'hFFFFCCDD, 9};

      repeat (2) @(posedge clk);
      #1;
      chk("reset wb_valid", 32'(wb_valid), 0);
      chk("reset wb_data", wb_data, 0);
      chk("reset wb_reg_r", 32'(wb_reg_r), 0);
      chk("reset dmem_req", 32'(dmem_req), 0);
      @(negedge clk) reset = 0;

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         set_in(vt[i].mv, vt[i].d0, vt[i].d1, vt[i].rd, vt[i].wr, vt[i].ext, vt[i].w,
                vt[i].jmp, vt[i].br, vt[i].inv, vt[i].rg);
         dmem_ack = vt[i].ack; dmem_rdata = vt[i].rdata;
         #1;
         chk($sformatf("v%0d stall", i), 32'(mem_stall), 32'(vt[i].e_stall));
         chk($sformatf("v%0d br_taken", i), 32'(br_taken), 32'(vt[i].e_tk));
         if (vt[i].e_tk) chk($sformatf("v%0d br_target", i), br_target, vt[i].e_tgt);
         chk($sformatf("v%0d fwd", i), mem_forward_data, vt[i].e_fwd);
         chk($sformatf("v%0d wen", i), 32'(mem_wen), 32'(vt[i].e_wen));
         if (vt[i].wr) begin
            chk($sformatf("v%0d wdata", i), dmem_wdata, vt[i].e_wdata);
            chk($sformatf("v%0d wstrb", i), 32'(dmem_wstrb), 32'(vt[i].e_wstrb));
            chk($sformatf("v%0d we", i), 32'(dmem_we), 1);
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vt[i].e_wbv));
         chk($sformatf("v%0d wb_data", i), wb_data, vt[i].e_wbd);
         chk($sformatf("v%0d wb_reg_r", i), 32'(wb_reg_r), 32'(vt[i].e_wbr));
      end

      // Half load with ack three cycles late: held request, single completion.
      @(negedge clk);
      set_in(1, 32'h2002, 0, 1, 0, 0, 1, 0, 0, 0, 4);
      dmem_ack = 0; dmem_rdata = 32'h12345678;
      req_cycles = 0; stall_cycles = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (mem_stall) stall_cycles++;
         chk("lh wait req", 32'(dmem_req), 1);
         chk("lh wait addr", dmem_addr, 32'h2000);
         @(posedge clk);
         #1;
         chk("lh wait wb_valid", 32'(wb_valid), 0);
         @(negedge clk);
      end
      chk("lh stall cycles", 32'(stall_cycles), 3);
      dmem_ack = 1; dmem_rdata = 32'hBEEF0000;
      #1;
      chk("lh ack stall", 32'(mem_stall), 0);
      chk("lh ack fwd", mem_forward_data, 32'h0000BEEF);
      if (dmem_req && dmem_ack) req_cycles++;
      @(posedge clk);
      #1;
      chk("lh wb_valid", 32'(wb_valid), 1);
      chk("lh wb_data", wb_data, 32'h0000BEEF);
      @(negedge clk);
      mem_valid = 0; dmem_ack = 0;
      #1;
      if (dmem_req) req_cycles++;
      chk("lh single request", 32'(req_cycles), 1);

      // Reset while waiting on the bus, then a stray ack with nothing requested.
      @(negedge clk);
      set_in(1, 32'h3000, 0, 1, 0, 0, 2, 0, 0, 0, 6);
      @(posedge clk);
      @(negedge clk);
      reset = 1;
      #1;
      chk("rst wait req drop", 32'(dmem_req), 0);
      @(posedge clk);
      #1;
      chk("rst wb_valid", 32'(wb_valid), 0);
      chk("rst wb_data", wb_data, 0);
      @(negedge clk);
      mem_valid = 0; reset = 0; dmem_ack = 1;
      #1;
      chk("late ack req", 32'(dmem_req), 0);
      @(posedge clk);
      #1;
      chk("late ack wb_valid", 32'(wb_valid), 0);
      @(negedge clk) dmem_ack = 0;

      // Randomized transactions with 0-3 cycle ack latency.
      m_wbv = 0; m_wbd = 0; m_wbr = 0;
      reset = 1;
      @(posedge clk);
      @(negedge clk) reset = 0;
      for (int t = 0; t < 300; t++) begin
         int op, dly;
         op = int'($urandom_range(0, 4));
         set_in($urandom_range(0, 3) != 0, $urandom, $urandom, op == 0, op == 1, $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)), op == 2, op == 3, $urandom_range(0, 1) == 1, 5'($urandom));
         dly = (op <= 1) ? int'($urandom_range(0, 3)) : 0;
         for (int c = 0; c <= dly; c++) begin
            dmem_ack = (c == dly); dmem_rdata = $urandom;
            #1;
            model();
            chk("rnd stall", 32'(mem_stall), 32'(m_stall));
            chk("rnd req", 32'(dmem_req), 32'(m_req));
            chk("rnd we", 32'(dmem_we), 32'(m_we));
            if (m_req) chk("rnd addr", dmem_addr, m_addr);
            if (m_we) begin
               chk("rnd wdata", dmem_wdata, m_wdata);
               chk("rnd wstrb", 32'(dmem_wstrb), 32'(m_wstrb));
            end
            chk("rnd br_taken", 32'(br_taken), 32'(m_tk));
            if (m_tk) chk("rnd br_target", br_target, m_tgt);
            if (!m_stall) chk("rnd fwd", mem_forward_data, m_fwd);
            chk("rnd wen", 32'(mem_wen), 32'(m_wen));
            model_clock();
            @(posedge clk);
            #1;
            chk("rnd wb_valid", 32'(wb_valid), 32'(m_wbv));
            chk("rnd wb_data", wb_data, m_wbd);
            chk("rnd wb_reg_r", 32'(wb_reg_r), 32'(m_wbr));
            @(negedge clk);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Memory stage of the 5-stage RV32IM pipeline; consumer end of the execute→memory register interface and producer of `mem_stall` back to execute.
- Performs loads and stores over a single-port data-bus request/acknowledge handshake.
- Resolves branches and jumps into a redirect, and registers results into the writeback stage.
- Holds the pipeline while a bus transaction is outstanding.

Parameters:
- None. Datapath is fixed at 32 bits.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  execute→memory register holds a live instruction
- mem_pc  in  32  instruction PC (debug/trace only)
- mem_data0  in  32  ALU result: load/store address, link value (pc+4) for jumps, compare result in bit 0 for branches
- mem_data1  in  32  store data for stores; branch/jump target for jmp/br
- mem_read  in  1  load
- mem_write  in  1  store
- mem_extend  in  1  1 = sign-extend load, 0 = zero-extend
- mem_width  in  2  0 = byte, 1 = half, 2 = word (3 illegal, treated as word)
- mem_jmp  in  1  unconditional jump
- mem_br  in  1  conditional branch
- mem_br_inv  in  1  invert branch condition
- wb_reg  in  5  destination register
- mem_stall  out  1  hold execute→memory register and everything upstream
- br_taken  out  1  redirect fetch and flush younger stages
- br_target  out  32  redirect PC
- mem_forward_data  out  32  value available for forwarding this cycle
- mem_wen  out  1  mem_forward_data is valid for wb_reg
- dmem_req  out  1  bus request
- dmem_we  out  1  write request
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data, lane-replicated
- dmem_wstrb  out  4  byte strobes
- dmem_ack  in  1  bus completion; may assert in the same cycle as dmem_req
- dmem_rdata  in  32  read data, valid with dmem_ack
- wb_valid  out  1  writeback register holds a result
- wb_data  out  32  result to write
- wb_reg_r  out  5  destination for writeback

Behaviour:
- FSM states: IDLE, WAIT.
  - IDLE: when `mem_valid & (mem_read|mem_write)`, assert dmem_req combinationally.
    - If dmem_ack is high the same cycle, complete and stay IDLE.
    - Otherwise go to WAIT.
  - WAIT: dmem_req stays high and dmem_addr/we/wdata/wstrb stay stable (inputs are frozen by the stall). On dmem_ack, go to IDLE.
- `mem_stall = mem_valid & (mem_read|mem_write) & ~dmem_ack`. Zero-wait bus gives no stall.
- Each access issues exactly one request, with no re-issue after ack.
- Store lanes, with a = mem_data0[1:0]:
  - byte: wdata = {4{d[7:0]}}, wstrb = 1<<a.
  - half: wdata = {2{d[15:0]}}, wstrb = 3<<{a[1],1'b0}.
  - word: wdata = d, wstrb = 4'hF.
- Load: select lane from dmem_rdata using the same a, then sign- or zero-extend according to mem_extend.
- Misaligned access with MEM_ALIGN_CHECK_EN undefined: the low address bits select lanes; half with a=1 uses lanes 0–1 and a=3 uses lanes 2–3 (high bit only).
- Branch:
  - `br_taken = mem_valid & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)))`.
  - `br_target = {mem_data1[31:1],1'b0}`.
  - br_taken is combinational and asserts for exactly one cycle per instruction, because jmp/br never stall here.
- Forwarding:
  - mem_forward_data = the extended load data for loads, mem_data0 otherwise.
  - `mem_wen = mem_valid & ~mem_write & (wb_reg != 0) & (~mem_read | dmem_ack)`.
- Writeback register, on each clk:
  - `wb_valid <= mem_valid & ~mem_stall`.
  - When that term is 1, load wb_data = mem_forward_data and wb_reg_r = (mem_write|mem_br) ? 0 : wb_reg. Otherwise hold wb_data and wb_reg_r.
- Reset:
  - FSM → IDLE; wb_valid = 0, wb_data = 0, wb_reg_r = 0.
  - Combinational outputs follow inputs; upstream drives mem_valid = 0.
  - Reset during WAIT drops dmem_req; the bus shares reset and aborts the transaction.
  - A late ack in IDLE with no request is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output mem_misaligned (1 bit) = `mem_valid & (mem_read|mem_write) & ((half & a[0]) | (word & a!=0))`.
  - A misaligned access suppresses dmem_req and does not stall.
  - Writeback gets wb_valid = 1 with wb_reg_r forced to 0, so no register is written.
- Undefined: no mem_misaligned port; misaligned accesses proceed as described in Behaviour.

Test Plan:
- Load byte, addr 0x1003, mem_extend = 1, dmem_rdata = 0x80FF_1234, ack in the same cycle → no stall; next cycle wb_data = 0xFFFF_FF80, wb_valid = 1.
- Load half, addr 0x2002, mem_extend = 0, ack after 3 cycles, rdata = 0xBEEF_0000 → mem_stall high for 3 cycles with dmem_req held and addr stable; wb_data = 0x0000_BEEF; exactly one request issued.
- Store half, data 0x1234_ABCD, addr 0x10 | 2 → dmem_wdata = 0xABCD_ABCD, dmem_wstrb = 4'b1100, dmem_we = 1; wb_reg_r = 0.
- Branch mem_br = 1, mem_data0 = 0, mem_br_inv = 1, mem_data1 = 0x0000_0201 → br_taken = 1 for one cycle, br_target = 0x0000_0200. Repeat with mem_br_inv = 0 → br_taken = 0.
- Jump mem_jmp = 1, mem_data0 = 0x104, wb_reg = 1 → br_taken = 1, mem_wen = 1, mem_forward_data = 0x104; next cycle wb_data = 0x104.
- Reset asserted in WAIT → dmem_req drops the same cycle; next cycle state IDLE and wb_valid = 0. With MEM_ALIGN_CHECK_EN, a word load at 0x1002 gives mem_misaligned = 1, dmem_req = 0 and no stall.
